layered_objects_mux: RTL and testbench

Parametrised, pipelined priority compositor for the VGA path. It selects one colour per pixel from NUM_LAYERS object layers plus a background. Selection uses fixed priority, with a per-layer enable mask that changes only on frame boundaries, and optional colour-key transparency. It also records which layers were actually visible in each frame. It sits between the object drawers and the VGA output register, replacing the hand-written fixed-priority mux.

---
 rtl/layered_objects_mux.sv | 135 +++++++++++++
 tb/tb_layered_objects_mux.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layered_objects_mux.sv
// rtl/layered_objects_mux.sv - pipelined fixed-priority layer compositor with frame-aligned enable mask
// Define OBJECTS_MUX_TRANSPARENCY_EN to make TRANSPARENT-coloured requests fall through to lower layers.
module layered_objects_mux #(
  parameter int                 NUM_LAYERS  = 16,
  parameter int                 COLOR_W     = 8,
  parameter logic [COLOR_W-1:0] TRANSPARENT = {COLOR_W{1'b1}},
  parameter int                 IDX_W       = $clog2(NUM_LAYERS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pixel_valid,
  input  logic [NUM_LAYERS-1:0]         draw_req,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [COLOR_W-1:0]            bg_rgb,
  input  logic                          frame_start,
  input  logic                          mask_wr,
  input  logic [NUM_LAYERS-1:0]         mask_data,
  output logic [COLOR_W-1:0]            rgb_out,
  output logic                          rgb_valid,
  output logic [IDX_W-1:0]              winner_idx,
  output logic [NUM_LAYERS-1:0]         frame_drawn
);

`ifdef OBJECTS_MUX_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(NUM_LAYERS);

  logic [NUM_LAYERS-1:0]         r_shadow_mask;
  logic [NUM_LAYERS-1:0]         r_active_mask;
  logic [NUM_LAYERS-1:0]         r_s1_q;
  logic [NUM_LAYERS*COLOR_W-1:0] r_s1_rgb;
  logic [COLOR_W-1:0]            r_s1_bg;
  logic                          r_s1_valid;
  logic [COLOR_W-1:0]            r_rgb_out;
  logic                          r_rgb_valid;
  logic [IDX_W-1:0]              r_winner;
  logic [NUM_LAYERS-1:0]         r_acc;
  logic [NUM_LAYERS-1:0]         r_frame_drawn;

  logic [NUM_LAYERS-1:0]         w_eff_mask;
  logic [NUM_LAYERS-1:0]         w_q;
  logic [IDX_W-1:0]              w_win_idx;
  logic [COLOR_W-1:0]            w_win_rgb;
  logic [NUM_LAYERS-1:0]         w_win_onehot;

  // A frame_start pixel already sees the mask it installs, including a same-cycle write.
  always_comb begin
    w_eff_mask = r_active_mask;
    if (frame_start) begin
      w_eff_mask = mask_wr ? mask_data : r_shadow_mask;
    end
    w_q = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_q[i] = draw_req[i] & w_eff_mask[i] &
               (!KEY_EN || (layer_rgb[i*COLOR_W +: COLOR_W] != TRANSPARENT));
    end
  end

  always_comb begin
    w_win_idx = BG_IDX;
    w_win_rgb = r_s1_bg;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_s1_q[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_rgb = r_s1_rgb[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Lowest set bit of q isolates the winner; blanked slots contribute nothing.
  assign w_win_onehot = r_s1_valid ? (r_s1_q & (~r_s1_q + NUM_LAYERS'(1))) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_mask <= '1;
      r_active_mask <= '1;
    end else begin
      if (mask_wr) begin
        r_shadow_mask <= mask_data;
      end
      if (frame_start) begin
        r_active_mask <= w_eff_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_q     <= '0;
      r_s1_rgb   <= '0;
      r_s1_bg    <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_q     <= w_q;
      r_s1_rgb   <= layer_rgb;
      r_s1_bg    <= bg_rgb;
      r_s1_valid <= pixel_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb_out   <= '0;
      r_rgb_valid <= 1'b0;
      r_winner    <= BG_IDX;
    end else begin
      r_rgb_valid <= r_s1_valid;
      r_rgb_out   <= r_s1_valid ? w_win_rgb : '0;
      r_winner    <= r_s1_valid ? w_win_idx : BG_IDX;
    end
  end

  // The winner registered on the frame_start edge opens the new frame's record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc         <= '0;
      r_frame_drawn <= '0;
    end else if (frame_start) begin
      r_frame_drawn <= r_acc;
      r_acc         <= w_win_onehot;
    end else begin
      r_acc         <= r_acc | w_win_onehot;
    end
  end

  assign rgb_out     = r_rgb_out;
  assign rgb_valid   = r_rgb_valid;
  assign winner_idx  = r_winner;
  assign frame_drawn = r_frame_drawn;

endmodule

// File: tb/tb_layered_objects_mux.sv
// tb/tb_layered_objects_mux.sv - self-checking bench for layered_objects_mux
// Honours OBJECTS_MUX_TRANSPARENCY_EN to pick the colour-key expectations.
module tb_layered_objects_mux;
  localparam int NL = 4;
  localparam int CW = 8;
  localparam int IW = 3;

`ifdef OBJECTS_MUX_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              pixel_valid = 1'b0;
  logic              frame_start = 1'b0;
  logic              mask_wr = 1'b0;
  logic [NL-1:0]     draw_req = '0;
  logic [NL-1:0]     mask_data = '0;
  logic [CW-1:0]     lc [NL];
  logic [CW-1:0]     bg_rgb = 8'h03;
  logic [NL*CW-1:0]  layer_rgb;
  logic [CW-1:0]     rgb_out;
  logic              rgb_valid;
  logic [IW-1:0]     winner_idx;
  logic [NL-1:0]     frame_drawn;

  int n_checks = 0;
  int n_errors = 0;

  assign layer_rgb = {lc[3], lc[2], lc[1], lc[0]};

  layered_objects_mux #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .draw_req(draw_req),
    .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .frame_start(frame_start),
    .mask_wr(mask_wr), .mask_data(mask_data), .rgb_out(rgb_out),
    .rgb_valid(rgb_valid), .winner_idx(winner_idx), .frame_drawn(frame_drawn)
  );

  always #5 clk = ~clk;

  // Reference model: what each pixel must resolve to, then a two-slot delay line.
  typedef struct packed {
    logic          v;
    logic [CW-1:0] rgb;
    logic [IW-1:0] win;
  } pix_t;

  localparam pix_t IDLE = '{v: 1'b0, rgb: '0, win: IW'(NL)};

  pix_t          m_pend, m_out;
  logic [NL-1:0] m_shadow, m_active, m_acc, m_drawn, m_eff;

  function automatic bit keyed(input logic [CW-1:0] c);
    return KEY_EN && (c == 8'hFF);
  endfunction

  function automatic pix_t resolve(input logic v, input logic [NL-1:0] req, input logic [NL-1:0] en);
    pix_t p;
    p = IDLE;
    if (v) begin
      p.v   = 1'b1;
      p.rgb = bg_rgb;
      for (int i = 0; i < NL; i++) begin
        if (req[i] && en[i] && !keyed(lc[i])) begin
          p.rgb = lc[i];
          p.win = IW'(i);
          break;
        end
      end
    end
    return p;
  endfunction

  task automatic model_reset();
    m_pend   = IDLE;
    m_out    = IDLE;
    m_shadow = '1;
    m_active = '1;
    m_acc    = '0;
    m_drawn  = '0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else begin
      m_eff = frame_start ? (mask_wr ? mask_data : m_shadow) : m_active;
      if (mask_wr) m_shadow = mask_data;
      if (frame_start) m_active = m_eff;
      m_out = m_pend;
      if (frame_start) begin
        m_drawn = m_acc;
        m_acc   = '0;
      end
      if (m_out.v && (int'(m_out.win) < NL)) m_acc = m_acc | (NL'(1) << m_out.win);
      m_pend = resolve(pixel_valid, draw_req, m_eff);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_valid", {31'd0, rgb_valid}, {31'd0, m_out.v});
      chk("cmp_rgb", {24'd0, rgb_out}, {24'd0, m_out.rgb});
      chk("cmp_win", {29'd0, winner_idx}, {29'd0, m_out.win});
      chk("cmp_drawn", {28'd0, frame_drawn}, {28'd0, m_drawn});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic px(input logic v, input logic [NL-1:0] req, input logic fs = 1'b0,
                    input logic mw = 1'b0, input logic [NL-1:0] md = '0);
    pixel_valid = v;
    draw_req    = req;
    frame_start = fs;
    mask_wr     = mw;
    mask_data   = md;
  endtask

  initial begin
    reset = 1'b1;
    lc[0] = 8'h11; lc[1] = 8'h1C; lc[2] = 8'hE0; lc[3] = 8'h88;
    tick(3);
    chk("rst_rgb", {24'd0, rgb_out}, 32'h0);
    chk("rst_valid", {31'd0, rgb_valid}, 32'h0);
    chk("rst_win", {29'd0, winner_idx}, 32'd4);
    chk("rst_drawn", {28'd0, frame_drawn}, 32'h0);
    reset = 1'b0;

    px(1'b1, 4'b0110); tick(3);
    chk("basic_rgb", {24'd0, rgb_out}, 32'h1C);
    chk("basic_win", {29'd0, winner_idx}, 32'd1);
    chk("basic_valid", {31'd0, rgb_valid}, 32'd1);

    px(1'b1, 4'b0000); tick(3);
    chk("bg_rgb", {24'd0, rgb_out}, 32'h03);
    chk("bg_win", {29'd0, winner_idx}, 32'd4);

    px(1'b0, 4'b0000); tick(3);
    chk("blank_rgb", {24'd0, rgb_out}, 32'h0);
    chk("blank_valid", {31'd0, rgb_valid}, 32'h0);
    chk("blank_win", {29'd0, winner_idx}, 32'd4);

    px(1'b1, 4'b0011); tick(3);
    chk("all_on_win", {29'd0, winner_idx}, 32'd0);

    // Same-cycle write at frame_start disables layer 0 for that very pixel.
    px(1'b1, 4'b0011, 1'b1, 1'b1, 4'b1110); tick;
    px(1'b1, 4'b0011); tick;
    chk("samecyc_win", {29'd0, winner_idx}, 32'd1);
    chk("samecyc_rgb", {24'd0, rgb_out}, 32'h1C);
    tick(2);
    chk("samecyc_hold", {29'd0, winner_idx}, 32'd1);

    // Mid-frame write only reaches the shadow mask.
    px(1'b1, 4'b0011, 1'b0, 1'b1, 4'b1101); tick;
    px(1'b1, 4'b0011); tick(3);
    chk("shadow_only_win", {29'd0, winner_idx}, 32'd1);

    px(1'b1, 4'b0011, 1'b1); tick;
    chk("pre_fs_win", {29'd0, winner_idx}, 32'd1);
    px(1'b1, 4'b0011); tick;
    chk("fs_pixel_win", {29'd0, winner_idx}, 32'd0);
    chk("fs_pixel_rgb", {24'd0, rgb_out}, 32'h11);

    // The pixel still in flight at this frame_start belongs to the new frame.
    px(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111); tick;
    px(1'b0, 4'b0000); tick(3);
    px(1'b0, 4'b0000, 1'b1); tick;
    chk("inflight_drawn", {28'd0, frame_drawn}, 32'b0001);
    px(1'b1, 4'b0001); tick;
    px(1'b1, 4'b1000); tick;
    px(1'b0, 4'b0100); tick;
    px(1'b0, 4'b0000); tick(3);
    chk("drawn_stable", {28'd0, frame_drawn}, 32'b0001);
    px(1'b0, 4'b0000, 1'b1); tick;
    px(1'b0, 4'b0000); tick;
    chk("drawn_1001", {28'd0, frame_drawn}, 32'b1001);

    lc[0] = 8'hFF; lc[1] = 8'h55;
    px(1'b1, 4'b0011); tick(3);
    if (KEY_EN) begin
      chk("key_rgb", {24'd0, rgb_out}, 32'h55);
      chk("key_win", {29'd0, winner_idx}, 32'd1);
    end else begin
      chk("nokey_rgb", {24'd0, rgb_out}, 32'hFF);
      chk("nokey_win", {29'd0, winner_idx}, 32'd0);
    end
    lc[0] = 8'hAA; lc[1] = 8'h1C;

    px(1'b1, 4'b0001); tick(2);
    chk("pre_rst_valid", {31'd0, rgb_valid}, 32'd1);
    chk("pre_rst_rgb", {24'd0, rgb_out}, 32'hAA);
    #2;
    reset = 1'b1;
    px(1'b0, 4'b0000);
    #1;
    chk("async_rgb", {24'd0, rgb_out}, 32'h0);
    chk("async_valid", {31'd0, rgb_valid}, 32'h0);
    chk("async_win", {29'd0, winner_idx}, 32'd4);
    chk("async_drawn", {28'd0, frame_drawn}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick;
    chk("no_stale_1", {31'd0, rgb_valid}, 32'h0);
    tick;
    chk("no_stale_2", {31'd0, rgb_valid}, 32'h0);
    chk("no_stale_rgb", {24'd0, rgb_out}, 32'h0);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
